instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Front-end fetch stage directly upstream of the instruction queue (IQ). Holds the fetch PC,
//  issues one read at a time on the I-side memory port, and pushes each returned
//  instruction and its address into the IQ via load_iq_fetch. A one-entry skid register
//  absorbs a response that returns while the IQ is full. Branch/jump redirects flush the
//  IQ and discard any in-flight response.
// PARAMETERS
//  RESET_PC    32'h4000_0060  fetch PC after reset
//  PC_STEP     4              byte increment per fetched instruction
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  redirect_valid   in   1   control-flow redirect (mispredict/jump) this cycle
//  redirect_pc      in   32  target PC, valid with redirect_valid
//  iq_really_full   in   1   IQ cannot accept a push this cycle
//  mem_i_resp       in   1   I-memory read complete; mem_i_rdata valid this cycle
//  mem_i_rdata      in   32  instruction word from I-memory
//  mem_i_read       out  1   I-memory read request
//  mem_i_address    out  32  I-memory read address (word aligned)
//  load_iq_fetch    out  1   push iq_instr/iq_addr into IQ this cycle
//  iq_instr         out  32  instruction being pushed
//  iq_addr          out  32  PC of instruction being pushed
//  flush_iq_fetch   out  1   clear IQ; combinational copy of redirect_valid
//  PC               out  32  current fetch PC (next address to request)
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, state=IDLE, skid empty. All outputs read 0 during
//   the reset cycle, except PC=RESET_PC.
//  States: IDLE (no request), WAIT (request outstanding), DROP (outstanding request to discard).
//  issue_ok = ~iq_really_full & ~skid_valid & ~redirect_valid.
//  IDLE: mem_i_read=0. If redirect_valid: pc<=redirect_pc and stay IDLE.
//   Else if issue_ok: ->WAIT with req_addr<=pc.
//  WAIT: mem_i_read=1, mem_i_address=req_addr. Address is held stable until mem_i_resp.
//   - resp & ~redirect: pc<=req_addr+PC_STEP. If ~iq_really_full, assert load_iq_fetch the
//     same cycle with iq_instr=mem_i_rdata and iq_addr=req_addr. Else capture both into skid.
//     Next state is WAIT (req_addr<=req_addr+PC_STEP) if the IQ accepted the word and the IQ
//     is not full; otherwise IDLE. Back-to-back requests are supported: 1 instr/cycle when
//     resp latency is 1.
//   - resp & redirect: discard data, no push, pc<=redirect_pc, ->IDLE.
//   - ~resp & redirect: pc<=redirect_pc, ->DROP.
//  DROP: mem_i_read=1 with the old req_addr until resp. The response is discarded and
//   load_iq_fetch=0. On resp ->IDLE. A further redirect in DROP updates pc only.
//  Skid drain: in any state, if skid_valid & ~iq_really_full & ~redirect_valid, then
//   load_iq_fetch=1 from skid and skid is cleared. No issue occurs that cycle; issue_ok is
//   evaluated next cycle.
//  Push sources: a skid push and a memory push never coincide, because a request is issued
//   only when skid is empty.
//  Redirect: flush_iq_fetch=redirect_valid (0-cycle). Skid is cleared. load_iq_fetch is forced
//   to 0 that cycle. Redirect has priority over every other event.
//  Arithmetic: PC adds wrap modulo 2^32. redirect_pc[1:0] is ignored (forced to 00).
//  Reset mid-request: state returns to IDLE immediately and mem_i_read drops. A late
//   mem_i_resp arriving in IDLE is ignored.
//  Invariant: at most one outstanding request; load_iq_fetch is never 1 while
//   iq_really_full=1.
// TESTING
//  T1 reset, resp latency 1, IQ never full -> mem_i_address 0x40000060,64,68... on
//     consecutive cycles; load_iq_fetch=1 every cycle after the first resp; iq_addr matches.
//  T2 iq_really_full rises the cycle resp arrives for 0x40000064 -> no push; skid holds it;
//     mem_i_read=0 next cycle. Full drops -> push 0x40000064 the next cycle, then fetch 0x68.
//  T3 redirect_pc=0x40000100 two cycles into a 5-cycle WAIT -> flush_iq_fetch pulse;
//     mem_i_read stays high at the old addr until resp; no push; next request to 0x40000100.
//  T4 redirect coincident with mem_i_resp -> no push; next request to redirect_pc.
//  T5 redirect while skid full -> skid cleared; the stale instruction is never pushed.
//  T6 rst asserted mid-WAIT -> next cycle mem_i_read=0, PC=RESET_PC; stray resp ignored.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: redirect input, I-memory read port and IQ push port.
// The fetch stage is the master; the surrounding core/memory/IQ is the slave.
interface instruction_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        iq_really_full;
    logic        mem_i_resp;
    logic [31:0] mem_i_rdata;
    logic        mem_i_read;
    logic [31:0] mem_i_address;
    logic        load_iq_fetch;
    logic [31:0] iq_instr;
    logic [31:0] iq_addr;
    logic        flush_iq_fetch;
    logic [31:0] PC;

    modport master (
        input  redirect_valid, redirect_pc, iq_really_full, mem_i_resp, mem_i_rdata,
        output mem_i_read, mem_i_address, load_iq_fetch, iq_instr, iq_addr,
               flush_iq_fetch, PC
    );

    modport slave (
        output redirect_valid, redirect_pc, iq_really_full, mem_i_resp, mem_i_rdata,
        input  mem_i_read, mem_i_address, load_iq_fetch, iq_instr, iq_addr,
               flush_iq_fetch, PC
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding I-memory read, pushes responses into the IQ,
// one-entry skid for a response that lands while the IQ is full, redirect flush/drop.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h4000_0060,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_addr;

    logic [31:0] w_redirect_pc;
    logic [31:0] w_next_addr;
    logic        w_resp_ok;
    logic        w_mem_push;
    logic        w_skid_push;
    logic        w_issue_ok;
    logic        w_read;

    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_next_addr   = r_req_addr + PC_STEP;
    assign w_resp_ok     = (r_state == S_WAIT) & bus.mem_i_resp & ~bus.redirect_valid;
    assign w_mem_push    = w_resp_ok & ~bus.iq_really_full;
    assign w_skid_push   = r_skid_valid & ~bus.iq_really_full & ~bus.redirect_valid;
    assign w_issue_ok    = ~bus.iq_really_full & ~r_skid_valid & ~bus.redirect_valid;
    assign w_read        = ~rst & ((r_state == S_WAIT) | (r_state == S_DROP));

    // Skid is only ever valid in IDLE, so the two push sources are exclusive.
    assign bus.mem_i_read     = w_read;
    assign bus.mem_i_address  = w_read ? r_req_addr : 32'd0;
    assign bus.load_iq_fetch  = ~rst & (w_mem_push | w_skid_push);
    assign bus.iq_instr       = rst         ? 32'd0 :
                                w_skid_push ? r_skid_instr :
                                w_mem_push  ? bus.mem_i_rdata : 32'd0;
    assign bus.iq_addr        = rst         ? 32'd0 :
                                w_skid_push ? r_skid_addr :
                                w_mem_push  ? r_req_addr : 32'd0;
    assign bus.flush_iq_fetch = ~rst & bus.redirect_valid;
    assign bus.PC             = rst ? RESET_PC : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_addr  <= 32'd0;
        end else begin
            if (bus.redirect_valid) begin
                r_skid_valid <= 1'b0;
                r_pc         <= w_redirect_pc;
            end else if (w_skid_push) begin
                r_skid_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue_ok) begin
                        r_state    <= S_WAIT;
                        r_req_addr <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_i_resp) begin
                        if (bus.redirect_valid) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_pc <= w_next_addr;
                            if (!bus.iq_really_full) begin
                                r_req_addr <= w_next_addr;
                            end else begin
                                r_skid_valid <= 1'b1;
                                r_skid_instr <= bus.mem_i_rdata;
                                r_skid_addr  <= r_req_addr;
                                r_state      <= S_IDLE;
                            end
                        end
                    end else if (bus.redirect_valid) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.mem_i_resp) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
